alu_ctrl_stage: RTL and testbench
=================================

Name: alu_ctrl_stage

Overview:
- Next-generation ALU control for the pipelined RV32 core: full RV32I ALU decode plus optional M-extension decode.
- Registers the result into the ID/EX boundary.
- Tracks multi-cycle multiply/divide occupancy so the hazard unit can stall the front end.
- Sits between the main decoder (ID) and the execute stage.

Parameters:
- SUPPORT_M, 1, 1 = decode funct7=0000001 R-type as M ops; 0 = flag them illegal.
- DIV_LATENCY, 8, EX cycles for DIV/DIVU/REM/REMU (legal range 1..64).
- MUL_LATENCY, 1, EX cycles for MUL/MULH (legal range 1..64).
- CTRL_W, 4, width of the ALU control code (legal ≥4); codes are zero-extended.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_op5  in  1  opcode bit 5 (1 = R-type, 0 = I-type ALU).
- id_funct3  in  3  instruction funct3.
- id_funct7  in  7  instruction funct7.
- id_alu_op  in  2  main-decoder ALU class.
- stall  in  1  hazard-unit hold of the ID/EX register.
- flush  in  1  kill the ID/EX contents (branch/exception).
- ex_alu_cntrl  out  CTRL_W  registered ALU control code.
- ex_valid  out  1  EX stage holds a valid op.
- ex_illegal  out  1  registered illegal-encoding flag.
- ex_multicycle  out  1  EX op has latency >1.
- md_busy  out  1  multi-cycle op still executing; front end must stall.
- md_done  out  1  multi-cycle op completes this cycle.

Behaviour:

Codes:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- 10 MUL, 11 MULH, 12 DIV, 13 DIVU, 14 REM, 15 REMU.

Decode (combinational, internal):
- alu_op=00 → ADD; alu_op=01 → SUB.
- alu_op=11 → ADD, illegal=1.
- alu_op=10, M case (SUPPORT_M=1, id_op5=1, funct7=0000001):
  - funct3 000 → MUL; 001/010/011 → MULH.
  - 100 → DIV; 101 → DIVU; 110 → REM; 111 → REMU.
- alu_op=10, all other cases:
  - funct3 000 → SUB if id_op5 & funct7[5], else ADD.
  - 001 → SLL; 010 → SLT; 011 → SLTU; 100 → XOR.
  - 101 → SRA if funct7[5], else SRL (regardless of id_op5).
  - 110 → OR; 111 → AND.
- Illegal when alu_op=10 and id_op5=1 with funct7 other than 0000000, 0100000, or (SUPPORT_M=1 and 0000001):
  - SUB/SRA forms with funct7=0100000 are legal only for funct3 000/101.
  - Illegal ops decode to ADD.
- multicycle = (DIV class and DIV_LATENCY>1) or (MUL class and MUL_LATENCY>1).

ID/EX register, priority flush > hold > load:
- Reset (async): all outputs 0, cnt=0.
- flush: ex_valid, ex_alu_cntrl, ex_illegal, ex_multicycle ← 0; cnt ← 0. This aborts any in-flight multi-cycle op.
- hold when stall | md_busy: all registers keep their value.
- Otherwise load:
  - ex_valid ← id_valid.
  - ex_alu_cntrl, ex_illegal, ex_multicycle ← decode if id_valid, else 0.
  - cnt ← LAT−1 if id_valid & multicycle, else 0.

Counter:
- Width $clog2(64).
- When not flushed and cnt≠0, cnt decrements every cycle, independent of stall.

Multi-cycle outputs:
- md_busy = ex_valid & ex_multicycle & (cnt≠0).
- md_done = ex_valid & ex_multicycle & (cnt==0).
- A LAT-cycle op asserts md_busy for LAT−1 cycles after entering EX (cycle N); md_done is high in cycle N+LAT−1.
- The op leaves EX on the next edge unless stall=1.
- Back-to-back multi-cycle ops: the second loads on the edge following md_done and reloads cnt.
- stall=1 while md_done=1: op held with md_done remaining high; cnt stays 0.
- flush during md_busy: md_busy drops the next cycle.

Test Plan:
- Reset mid-DIV (cnt=5, rst_n low) → all outputs 0 immediately, asynchronously.
- id_valid=1, alu_op=10, op5=1, funct3=000, funct7=0100000 → ex_alu_cntrl=1 (SUB) one edge later. Same with op5=0 (ADDI) → 0 (ADD).
- alu_op=10, funct3=101, funct7=0100000, op5=0 → 9 (SRAI). funct7=0000000 → 8 (SRL).
- SUPPORT_M=1, DIV_LATENCY=8, funct7=0000001, funct3=100:
  - ex_alu_cntrl=12, ex_multicycle=1.
  - md_busy high for 7 cycles; md_done high on cycle 8.
  - Next ID op enters on edge 9.
- SUPPORT_M=0, funct7=0000001 → ex_illegal=1, ex_alu_cntrl=0. Also alu_op=11 → ex_illegal=1.
- DIV in flight, flush at busy cycle 3 → next cycle ex_valid=0, md_busy=0. A following ADD loads on the edge after that.

Source files
------------

// File: rtl/alu_ctrl_stage.sv
// ALU control stage for the RV32 pipeline: RV32I/M ALU decode registered into ID/EX,
// with an occupancy counter that reports multi-cycle mul/div progress to the hazard unit.
module alu_ctrl_stage #(
  parameter int SUPPORT_M   = 1,
  parameter int DIV_LATENCY = 8,
  parameter int MUL_LATENCY = 1,
  parameter int CTRL_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              id_op5,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [1:0]        id_alu_op,
  input  logic              stall,
  input  logic              flush,
  output logic [CTRL_W-1:0] ex_alu_cntrl,
  output logic              ex_valid,
  output logic              ex_illegal,
  output logic              ex_multicycle,
  output logic              md_busy,
  output logic              md_done
);

  localparam int CNT_W = $clog2(64);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);
  localparam bit DIV_MC = (DIV_LATENCY > 1);
  localparam bit MUL_MC = (MUL_LATENCY > 1);
  localparam bit HAS_M  = (SUPPORT_M != 0);

  typedef enum logic [3:0] {
    C_ADD  = 4'd0,  C_SUB  = 4'd1,  C_AND  = 4'd2,  C_OR   = 4'd3,
    C_XOR  = 4'd4,  C_SLT  = 4'd5,  C_SLTU = 4'd6,  C_SLL  = 4'd7,
    C_SRL  = 4'd8,  C_SRA  = 4'd9,  C_MUL  = 4'd10, C_MULH = 4'd11,
    C_DIV  = 4'd12, C_DIVU = 4'd13, C_REM  = 4'd14, C_REMU = 4'd15
  } alu_code_e;

  alu_code_e dec_code;
  logic      dec_illegal;
  logic      dec_is_mul;
  logic      dec_is_div;
  logic      dec_multicycle;
  logic      m_case;

  always_comb begin
    dec_code    = C_ADD;
    dec_illegal = 1'b0;
    dec_is_mul  = 1'b0;
    dec_is_div  = 1'b0;
    m_case      = HAS_M && id_op5 && (id_funct7 == 7'b0000001);
    unique case (id_alu_op)
      2'b00: dec_code = C_ADD;
      2'b01: dec_code = C_SUB;
      2'b11: dec_illegal = 1'b1;
      default: begin
        if (m_case) begin
          unique case (id_funct3)
            3'b000:                 begin dec_code = C_MUL;  dec_is_mul = 1'b1; end
            3'b001, 3'b010, 3'b011: begin dec_code = C_MULH; dec_is_mul = 1'b1; end
            3'b100:                 begin dec_code = C_DIV;  dec_is_div = 1'b1; end
            3'b101:                 begin dec_code = C_DIVU; dec_is_div = 1'b1; end
            3'b110:                 begin dec_code = C_REM;  dec_is_div = 1'b1; end
            default:                begin dec_code = C_REMU; dec_is_div = 1'b1; end
          endcase
        end else begin
          // funct7 is only an opcode field for R-type; for I-type it is immediate bits
          if (id_op5) begin
            if (id_funct7 == 7'b0100000)
              dec_illegal = !((id_funct3 == 3'b000) || (id_funct3 == 3'b101));
            else if (id_funct7 != 7'b0000000)
              dec_illegal = 1'b1;
          end
          if (!dec_illegal) begin
            unique case (id_funct3)
              3'b000:  dec_code = (id_op5 && id_funct7[5]) ? C_SUB : C_ADD;
              3'b001:  dec_code = C_SLL;
              3'b010:  dec_code = C_SLT;
              3'b011:  dec_code = C_SLTU;
              3'b100:  dec_code = C_XOR;
              3'b101:  dec_code = id_funct7[5] ? C_SRA : C_SRL;
              3'b110:  dec_code = C_OR;
              default: dec_code = C_AND;
            endcase
          end
        end
      end
    endcase
    dec_multicycle = (dec_is_div && DIV_MC) || (dec_is_mul && MUL_MC);
  end

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] cntrl_q, cntrl_d;
  logic              illegal_q, illegal_d;
  logic              mc_q, mc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hold;

  assign md_busy = valid_q & mc_q & (cnt_q != '0);
  assign md_done = valid_q & mc_q & (cnt_q == '0);
  assign hold    = stall | md_busy;

  always_comb begin
    valid_d   = valid_q;
    cntrl_d   = cntrl_q;
    illegal_d = illegal_q;
    mc_d      = mc_q;
    cnt_d     = cnt_q;
    if (flush) begin
      valid_d   = 1'b0;
      cntrl_d   = '0;
      illegal_d = 1'b0;
      mc_d      = 1'b0;
      cnt_d     = '0;
    end else if (hold) begin
      // the occupancy counter keeps running while the stage is held
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else begin
      valid_d   = id_valid;
      cntrl_d   = id_valid ? CTRL_W'(dec_code) : '0;
      illegal_d = id_valid & dec_illegal;
      mc_d      = id_valid & dec_multicycle;
      if (id_valid && dec_multicycle)
        cnt_d = dec_is_div ? DIV_CNT : MUL_CNT;
      else
        cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      cntrl_q   <= '0;
      illegal_q <= 1'b0;
      mc_q      <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      cntrl_q   <= cntrl_d;
      illegal_q <= illegal_d;
      mc_q      <= mc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_cntrl  = cntrl_q;
  assign ex_illegal    = illegal_q;
  assign ex_multicycle = mc_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: one instance with M support (DIV_LATENCY=8),
// one without, driven from the same ID-side stimulus.
module tb_alu_ctrl_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_op5, stall, flush;
  logic [2:0] id_funct3;
  logic [6:0] id_funct7;
  logic [1:0] id_alu_op;

  logic [3:0] ex_alu_cntrl, nm_alu_cntrl;
  logic       ex_valid, ex_illegal, ex_multicycle, md_busy, md_done;
  logic       nm_valid, nm_illegal, nm_multicycle, nm_busy, nm_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_ctrl_stage #(.SUPPORT_M(1), .DIV_LATENCY(8), .MUL_LATENCY(1), .CTRL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op5(id_op5),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_alu_op(id_alu_op),
    .stall(stall), .flush(flush), .ex_alu_cntrl(ex_alu_cntrl), .ex_valid(ex_valid),
    .ex_illegal(ex_illegal), .ex_multicycle(ex_multicycle), .md_busy(md_busy),
    .md_done(md_done));

  alu_ctrl_stage #(.SUPPORT_M(0), .DIV_LATENCY(8), .MUL_LATENCY(1), .CTRL_W(4)) dut_nm (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op5(id_op5),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_alu_op(id_alu_op),
    .stall(stall), .flush(flush), .ex_alu_cntrl(nm_alu_cntrl), .ex_valid(nm_valid),
    .ex_illegal(nm_illegal), .ex_multicycle(nm_multicycle), .md_busy(nm_busy),
    .md_done(nm_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aop, input logic op5,
                       input logic [2:0] f3, input logic [6:0] f7);
    id_valid  = v;
    id_alu_op = aop;
    id_op5    = op5;
    id_funct3 = f3;
    id_funct7 = f7;
  endtask

  typedef struct {
    logic [1:0] aop;
    logic       op5;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 3'd0, 7'd0);
    #12;
    check("reset_valid", ex_valid, 0);
    check("reset_cntrl", ex_alu_cntrl, 0);
    check("reset_busy",  md_busy, 0);
    check("reset_done",  md_done, 0);
    rst_n = 1'b1;
    cyc();

    vecs = '{
      '{2'b10, 1'b1, 3'd0, 7'h20, 4'd1,  1'b0},
      '{2'b10, 1'b0, 3'd0, 7'h20, 4'd0,  1'b0},
      '{2'b10, 1'b0, 3'd5, 7'h20, 4'd9,  1'b0},
      '{2'b10, 1'b0, 3'd5, 7'h00, 4'd8,  1'b0},
      '{2'b10, 1'b1, 3'd5, 7'h20, 4'd9,  1'b0},
      '{2'b10, 1'b1, 3'd2, 7'h00, 4'd5,  1'b0},
      '{2'b10, 1'b1, 3'd3, 7'h00, 4'd6,  1'b0},
      '{2'b10, 1'b1, 3'd4, 7'h00, 4'd4,  1'b0},
      '{2'b10, 1'b1, 3'd6, 7'h00, 4'd3,  1'b0},
      '{2'b10, 1'b1, 3'd7, 7'h00, 4'd2,  1'b0},
      '{2'b10, 1'b1, 3'd1, 7'h00, 4'd7,  1'b0},
      '{2'b00, 1'b1, 3'd7, 7'h20, 4'd0,  1'b0},
      '{2'b01, 1'b0, 3'd0, 7'h00, 4'd1,  1'b0},
      '{2'b11, 1'b1, 3'd6, 7'h00, 4'd0,  1'b1},
      '{2'b10, 1'b1, 3'd1, 7'h20, 4'd0,  1'b1},
      '{2'b10, 1'b1, 3'd0, 7'h10, 4'd0,  1'b1},
      '{2'b10, 1'b0, 3'd6, 7'h20, 4'd3,  1'b0},
      '{2'b10, 1'b1, 3'd0, 7'h01, 4'd10, 1'b0},
      '{2'b10, 1'b1, 3'd3, 7'h01, 4'd11, 1'b0}
    };
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].aop, vecs[i].op5, vecs[i].f3, vecs[i].f7);
      cyc();
      check($sformatf("dec%0d_cntrl", i), ex_alu_cntrl, vecs[i].code);
      check($sformatf("dec%0d_ill", i), ex_illegal, vecs[i].ill);
      check($sformatf("dec%0d_valid", i), ex_valid, 1);
      check($sformatf("dec%0d_mc", i), ex_multicycle, 0);
    end

    // M encodings without M support are illegal ADDs
    drive(1'b1, 2'b10, 1'b1, 3'd0, 7'h01);
    cyc();
    check("nm_mul_ill", nm_illegal, 1);
    check("nm_mul_cntrl", nm_alu_cntrl, 0);

    // id_valid low loads a bubble
    drive(1'b0, 2'b10, 1'b1, 3'd4, 7'h00);
    cyc();
    check("bubble_valid", ex_valid, 0);
    check("bubble_cntrl", ex_alu_cntrl, 0);

    // stall holds a single-cycle op
    drive(1'b1, 2'b10, 1'b1, 3'd4, 7'h00);
    cyc();
    drive(1'b1, 2'b10, 1'b1, 3'd7, 7'h00);
    stall = 1'b1;
    cyc();
    check("stall_hold", ex_alu_cntrl, 4);
    stall = 1'b0;
    cyc();
    check("stall_release", ex_alu_cntrl, 2);

    // DIV: 7 busy cycles, done on the 8th, next op loads on the following edge
    drive(1'b1, 2'b10, 1'b1, 3'd4, 7'h01);
    cyc();
    check("div_cntrl", ex_alu_cntrl, 12);
    check("div_mc", ex_multicycle, 1);
    check("nm_div_ill", nm_illegal, 1);
    check("nm_div_cntrl", nm_alu_cntrl, 0);
    check("nm_div_busy", nm_busy, 0);
    drive(1'b1, 2'b01, 1'b0, 3'd0, 7'h00);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("div_busy%0d", i + 1), md_busy, 1);
      check($sformatf("div_notdone%0d", i + 1), md_done, 0);
      cyc();
    end
    check("div_done", md_done, 1);
    check("div_done_busy", md_busy, 0);
    check("div_done_cntrl", ex_alu_cntrl, 12);
    cyc();
    check("div_next_cntrl", ex_alu_cntrl, 1);
    check("div_next_mc", ex_multicycle, 0);
    check("div_next_done", md_done, 0);

    // stall while md_done holds the op with md_done high
    drive(1'b1, 2'b10, 1'b1, 3'd6, 7'h01);
    cyc();
    check("rem_cntrl", ex_alu_cntrl, 14);
    drive(1'b1, 2'b01, 1'b0, 3'd0, 7'h00);
    repeat (7) cyc();
    check("rem_done", md_done, 1);
    stall = 1'b1;
    cyc();
    check("rem_stall_done", md_done, 1);
    check("rem_stall_busy", md_busy, 0);
    check("rem_stall_cntrl", ex_alu_cntrl, 14);
    stall = 1'b0;
    cyc();
    check("rem_after_cntrl", ex_alu_cntrl, 1);

    // flush in busy cycle 3 aborts the divide
    drive(1'b1, 2'b10, 1'b1, 3'd5, 7'h01);
    cyc();
    check("divu_cntrl", ex_alu_cntrl, 13);
    drive(1'b1, 2'b00, 1'b0, 3'd0, 7'h00);
    cyc();
    cyc();
    check("flush_pre_busy", md_busy, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_valid", ex_valid, 0);
    check("flush_busy", md_busy, 0);
    check("flush_done", md_done, 0);
    cyc();
    check("post_flush_valid", ex_valid, 1);
    check("post_flush_cntrl", ex_alu_cntrl, 0);
    check("post_flush_busy", md_busy, 0);

    // asynchronous reset in the middle of a divide (cnt=5)
    drive(1'b1, 2'b10, 1'b1, 3'd7, 7'h01);
    cyc();
    check("remu_cntrl", ex_alu_cntrl, 15);
    drive(1'b0, 2'b00, 1'b0, 3'd0, 7'h00);
    cyc();
    cyc();
    check("mid_div_busy", md_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ex_valid, 0);
    check("arst_cntrl", ex_alu_cntrl, 0);
    check("arst_mc", ex_multicycle, 0);
    check("arst_busy", md_busy, 0);
    check("arst_done", md_done, 0);
    #3 rst_n = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 3'd2, 7'h00);
    cyc();
    check("after_rst_cntrl", ex_alu_cntrl, 5);
    check("after_rst_busy", md_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
